// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: program counter, next-PC priority resolution and
// a pending-redirect latch that rides out multi-cycle instruction-memory returns.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        exception,
  input  logic [31:0] exc_pc,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        flush_if,
  output logic [31:0] epc
);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t      state, state_next;
  logic [31:0] pc_next, epc_next, pend_pc, pend_pc_next, target;
  logic        pend_sticky, sticky_next;
  logic        irq_eff, trap, redirect, take, valid_c, flush_c;

  // Mode bit is preserved: sequential flow never leaves user or kernel space.
  assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};
  assign imem_req = 1'b1;
  assign if_valid = valid_c & ~reset;
  assign flush_if = flush_c & ~reset;

  always_comb begin
    irq_eff  = irq & ~pc[31];
    trap     = exception | irq_eff;
    redirect = trap | branch_taken | jr | jump;
    if (exception)         target = EXC_VEC;
    else if (irq_eff)      target = IRQ_VEC;
    else if (branch_taken) target = {pc[31], branch_target[30:0]};
    else if (jr)           target = jr_target;
    else                   target = {pc[31], jump_target[30:0]};
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pend_pc_next = pend_pc;
    sticky_next  = pend_sticky;
    valid_c      = 1'b0;
    flush_c      = 1'b0;
    take         = 1'b0;
    epc_next     = exception ? exc_pc : (irq_eff ? pc : epc);
    case (state)
      FETCH: begin
        if (redirect) begin
          flush_c = 1'b1;
          if (imem_ready) begin
            pc_next = target;
          end else begin
            pend_pc_next = target;
            sticky_next  = trap;
            state_next   = DRAIN;
          end
        end else if (imem_ready && !stall) begin
          valid_c = 1'b1;
          pc_next = pc_plus4;
        end
      end
      DRAIN: begin
        // A pending trap is only displaced by another trap.
        take    = redirect & (~pend_sticky | trap);
        flush_c = redirect;
        if (imem_ready) begin
          pc_next     = take ? target : pend_pc;
          sticky_next = 1'b0;
          state_next  = FETCH;
        end else if (take) begin
          pend_pc_next = target;
          sticky_next  = pend_sticky | trap;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_VEC;
      epc         <= 32'h0;
      pend_pc     <= 32'h0;
      pend_sticky <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      epc         <= epc_next;
      pend_pc     <= pend_pc_next;
      pend_sticky <= sticky_next;
    end
  end

endmodule
